// File: rtl/dsp_post_add_out.sv
// ---------------------------------------------------------------------------
// dsp_post_add_out
//
// Post-adder / output stage of a DSP slice. Two operand multiplexers (X and Z)
// feed a 48-bit adder/subtractor with a carry-in. The 48-bit result and its
// carry/borrow bit are each captured in an enabled register. Parameters choose
// whether the outputs come from those registers or straight from the adder.
//
// Parameters
//   PREG        1 = P taken from the P register, 0 = combinational result
//   CARRYOUTREG 1 = CARRYOUT taken from the carry register, 0 = combinational
//   CARRYINSEL  "OPMODE5" = carry-in is opmode[5], "CARRYIN" = CARRYIN port
//               (any other value behaves as "OPMODE5")
//
// Ports
//   CLK        clock; all state updates on the rising edge
//   rst        asynchronous active-high reset of both registers
//   CEP        P register clock enable
//   CECY       carry register clock enable
//   opmode     [1:0] X select, [3:2] Z select, [5] carry-in, [7] 1 = subtract
//   M          36-bit unsigned multiplier product
//   DAB        {D[11:0], A[17:0], B[17:0]}
//   C          C operand
//   PCIN       cascade input from the upstream slice
//   CARRYIN    external carry-in
//   P          post-adder result
//   PCOUT      cascade output, identical to P
//   CARRYOUT   carry (add) or borrow (subtract) bit
//   CARRYOUTF  fabric copy of CARRYOUT
// ---------------------------------------------------------------------------
module dsp_post_add_out #(
    parameter int PREG        = 1,
    parameter int CARRYOUTREG = 1,
    parameter     CARRYINSEL  = "OPMODE5"
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic        CEP,
    input  logic        CECY,
    input  logic [7:0]  opmode,
    input  logic [35:0] M,
    input  logic [47:0] DAB,
    input  logic [47:0] C,
    input  logic [47:0] PCIN,
    input  logic        CARRYIN,
    output logic [47:0] P,
    output logic [47:0] PCOUT,
    output logic        CARRYOUT,
    output logic        CARRYOUTF
);

    // Only the exact string "CARRYIN" selects the port; anything else falls
    // back to opmode[5].
    localparam bit USE_CARRYIN_PORT = (CARRYINSEL == "CARRYIN");

    typedef enum logic [1:0] {
        X_ZERO = 2'd0,
        X_M    = 2'd1,
        X_P    = 2'd2,
        X_DAB  = 2'd3
    } x_sel_e;

    typedef enum logic [1:0] {
        Z_ZERO = 2'd0,
        Z_PCIN = 2'd1,
        Z_P    = 2'd2,
        Z_C    = 2'd3
    } z_sel_e;

    logic [47:0] p_q;
    logic [47:0] p_d;
    logic        cy_q;
    logic        cy_d;

    x_sel_e      x_sel;
    z_sel_e      z_sel;
    logic [47:0] x_mux;
    logic [47:0] z_mux;
    logic        cin;
    logic [48:0] sum;
    logic [47:0] r;
    logic        cy;

    // ------------------------------------------------------------------
    // Operand selection. Feedback always comes from the P register, never
    // from the combinational result, so PREG=0 cannot form a loop.
    // ------------------------------------------------------------------
    always_comb begin
        x_sel = x_sel_e'(opmode[1:0]);
        z_sel = z_sel_e'(opmode[3:2]);

        x_mux = '0;
        unique case (x_sel)
            X_ZERO: x_mux = '0;
            X_M:    x_mux = {12'h000, M};
            X_P:    x_mux = p_q;
            X_DAB:  x_mux = DAB;
            default: x_mux = '0;
        endcase

        z_mux = '0;
        unique case (z_sel)
            Z_ZERO: z_mux = '0;
            Z_PCIN: z_mux = PCIN;
            Z_P:    z_mux = p_q;
            Z_C:    z_mux = C;
            default: z_mux = '0;
        endcase

        cin = USE_CARRYIN_PORT ? CARRYIN : opmode[5];
    end

    // ------------------------------------------------------------------
    // 49-bit adder/subtractor. In subtract mode bit 48 is the borrow of
    // Z - (X + CIN); results wrap modulo 2^49.
    // ------------------------------------------------------------------
    always_comb begin
        if (opmode[7]) begin
            sum = {1'b0, z_mux} - ({1'b0, x_mux} + {48'h0, cin});
        end else begin
            sum = {1'b0, z_mux} + {1'b0, x_mux} + {48'h0, cin};
        end
        r  = sum[47:0];
        cy = sum[48];
    end

    // ------------------------------------------------------------------
    // Register next-state: load when enabled, otherwise hold. Both registers
    // clock regardless of PREG / CARRYOUTREG since P feedback needs p_q.
    // ------------------------------------------------------------------
    always_comb begin
        p_d  = CEP  ? r  : p_q;
        cy_d = CECY ? cy : cy_q;
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            p_q  <= '0;
            cy_q <= 1'b0;
        end else begin
            p_q  <= p_d;
            cy_q <= cy_d;
        end
    end

    // ------------------------------------------------------------------
    // Output selection
    // ------------------------------------------------------------------
    always_comb begin
        P         = (PREG != 0)        ? p_q  : r;
        PCOUT     = P;
        CARRYOUT  = (CARRYOUTREG != 0) ? cy_q : cy;
        CARRYOUTF = CARRYOUT;
    end

endmodule

// File: tb/tb_dsp_post_add_out.sv
// ---------------------------------------------------------------------------
// tb_dsp_post_add_out
//
// Three instances share one set of inputs:
//   0: PREG=1, CARRYOUTREG=1, CARRYINSEL="OPMODE5"
//   1: PREG=1, CARRYOUTREG=1, CARRYINSEL="CARRYIN"
//   2: PREG=0, CARRYOUTREG=0, CARRYINSEL="OPMODE5"
// A behavioural model computes the expected register contents with plain
// integer arithmetic; a compare process checks every output of every
// instance on each falling edge. Directed literal checks pin the model.
// ---------------------------------------------------------------------------
module tb_dsp_post_add_out;

    logic        CLK;
    logic        rst;
    logic        CEP;
    logic        CECY;
    logic [7:0]  opmode;
    logic [35:0] M;
    logic [47:0] DAB;
    logic [47:0] C;
    logic [47:0] PCIN;
    logic        CARRYIN;

    logic [47:0] p_o   [3];
    logic [47:0] pc_o  [3];
    logic        co_o  [3];
    logic        cof_o [3];

    int tests_run;
    int tests_failed;

    localparam logic [47:0] ONES = 48'hFFFF_FFFF_FFFF;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    dsp_post_add_out #(.PREG(1), .CARRYOUTREG(1), .CARRYINSEL("OPMODE5")) u_dut0 (
        .CLK(CLK), .rst(rst), .CEP(CEP), .CECY(CECY), .opmode(opmode), .M(M),
        .DAB(DAB), .C(C), .PCIN(PCIN), .CARRYIN(CARRYIN),
        .P(p_o[0]), .PCOUT(pc_o[0]), .CARRYOUT(co_o[0]), .CARRYOUTF(cof_o[0])
    );

    dsp_post_add_out #(.PREG(1), .CARRYOUTREG(1), .CARRYINSEL("CARRYIN")) u_dut1 (
        .CLK(CLK), .rst(rst), .CEP(CEP), .CECY(CECY), .opmode(opmode), .M(M),
        .DAB(DAB), .C(C), .PCIN(PCIN), .CARRYIN(CARRYIN),
        .P(p_o[1]), .PCOUT(pc_o[1]), .CARRYOUT(co_o[1]), .CARRYOUTF(cof_o[1])
    );

    dsp_post_add_out #(.PREG(0), .CARRYOUTREG(0), .CARRYINSEL("OPMODE5")) u_dut2 (
        .CLK(CLK), .rst(rst), .CEP(CEP), .CECY(CECY), .opmode(opmode), .M(M),
        .DAB(DAB), .C(C), .PCIN(PCIN), .CARRYIN(CARRYIN),
        .P(p_o[2]), .PCOUT(pc_o[2]), .CARRYOUT(co_o[2]), .CARRYOUTF(cof_o[2])
    );

    // ---------------- behavioural model ----------------
    // Result of the post-adder as a 49-bit number: low 48 bits = R, bit 48 = CY.
    function automatic logic [48:0] model_res(input logic [7:0] op, input logic [35:0] m,
                                              input logic [47:0] dab, input logic [47:0] c,
                                              input logic [47:0] pcin, input logic [47:0] preg,
                                              input logic cin);
        longint unsigned x, z, res;
        case (op[1:0])
            2'd0: x = 0;
            2'd1: x = longint'(m);
            2'd2: x = longint'(preg);
            default: x = longint'(dab);
        endcase
        case (op[3:2])
            2'd0: z = 0;
            2'd1: z = longint'(pcin);
            2'd2: z = longint'(preg);
            default: z = longint'(c);
        endcase
        if (op[7]) res = z - x - longint'(cin);
        else       res = z + x + longint'(cin);
        return res[48:0];   // 64-bit wrap, keep modulo 2^49
    endfunction

    function automatic logic model_cin(input int idx);
        return (idx == 1) ? CARRYIN : opmode[5];
    endfunction

    function automatic bit preg_of(input int idx);
        return idx != 2;
    endfunction

    logic [47:0] mp  [3];
    logic        mcy [3];

    always @(posedge CLK or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                mp[i]  <= '0;
                mcy[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                logic [48:0] rr;
                rr = model_res(opmode, M, DAB, C, PCIN, mp[i], model_cin(i));
                if (CEP)  mp[i]  <= rr[47:0];
                if (CECY) mcy[i] <= rr[48];
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- every-cycle compare ----------------
    always @(negedge CLK) begin
        for (int i = 0; i < 3; i++) begin
            logic [48:0] rr;
            logic [47:0] ep;
            logic        ec;
            rr = model_res(opmode, M, DAB, C, PCIN, mp[i], model_cin(i));
            ep = preg_of(i) ? mp[i]  : rr[47:0];
            ec = preg_of(i) ? mcy[i] : rr[48];
            check($sformatf("model_p%0d", i),   64'(p_o[i]),   64'(ep));
            check($sformatf("model_pc%0d", i),  64'(pc_o[i]),  64'(ep));
            check($sformatf("model_co%0d", i),  64'(co_o[i]),  64'(ec));
            check($sformatf("model_cof%0d", i), 64'(cof_o[i]), 64'(ec));
        end
    end

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst = 1'b1; CEP = 1'b1; CECY = 1'b1; opmode = 8'h00;
        M = '0; DAB = '0; C = '0; PCIN = '0; CARRYIN = 1'b0;
        step; step;
        check("rst_p0", 64'(p_o[0]), 64'd0);
        check("rst_co0", 64'(co_o[0]), 64'd0);

        // C + M registered vs combinational
        opmode = 8'h0D; C = 48'd100; M = 36'd25; rst = 1'b0;
        #1;
        check("pre_edge_p0", 64'(p_o[0]), 64'd0);
        check("comb_p2_125", 64'(p_o[2]), 64'd125);
        step;
        check("reg_p0_125", 64'(p_o[0]), 64'd125);
        check("reg_co0_0", 64'(co_o[0]), 64'd0);

        // accumulate from reset
        rst = 1'b1; #1; rst = 1'b0;
        opmode = 8'h09; M = 36'd10;
        for (int k = 1; k <= 4; k++) begin
            step;
            check($sformatf("acc_%0d", k), 64'(p_o[0]), 64'(10 * k));
        end
        CEP = 1'b0;
        step;
        check("acc_hold", 64'(p_o[0]), 64'd40);

        // asynchronous reset between edges, held against CEP=1
        CEP = 1'b1;
        #1 rst = 1'b1;
        #1;
        check("async_rst_p0", 64'(p_o[0]), 64'd0);
        check("async_rst_co0", 64'(co_o[0]), 64'd0);
        step;
        check("rst_held_p0", 64'(p_o[0]), 64'd0);
        rst = 1'b0;
        step;
        check("post_rst_first", 64'(p_o[0]), 64'd10);

        // subtract with borrow
        opmode = 8'h8D; C = 48'd5; M = 36'd7; CARRYIN = 1'b0;
        step;
        check("sub_p0", 64'(p_o[0]), 64'hFFFF_FFFF_FFFE);
        check("sub_co0", 64'(co_o[0]), 64'd1);
        check("sub_p1", 64'(p_o[1]), 64'hFFFF_FFFF_FFFE);

        // DAB + C + carry-in; instance 0 sees opmode[5]=0, instance 1 CARRYIN=1
        opmode = 8'h0F; DAB = ONES; C = ONES; CARRYIN = 1'b1;
        step;
        check("cin_port_p1", 64'(p_o[1]), 64'(ONES));
        check("cin_port_co1", 64'(co_o[1]), 64'd1);
        check("cin_port_cof1", 64'(cof_o[1]), 64'd1);
        check("cin_op5_p0", 64'(p_o[0]), 64'hFFFF_FFFF_FFFE);
        check("cin_op5_co0", 64'(co_o[0]), 64'd1);

        // combinational path tracks inputs without a clock edge
        opmode = 8'h0D; C = 48'd3; M = 36'd4;
        #1;
        check("comb_p2_7", 64'(p_o[2]), 64'd7);
        check("comb_pc2_7", 64'(pc_o[2]), 64'd7);
        M = 36'd6;
        #1;
        check("comb_p2_9", 64'(p_o[2]), 64'd9);
        check("comb_pc2_9", 64'(pc_o[2]), 64'd9);
        check("comb_co2_0", 64'(co_o[2]), 64'd0);
        step;

        // X = Z = P feedback
        opmode = 8'h0C; C = 48'd100;
        step;
        opmode = 8'h0A;
        step;
        check("fb_double", 64'(p_o[0]), 64'd200);
        opmode = 8'h8A;
        step;
        check("fb_sub_zero", 64'(p_o[0]), 64'd0);
        opmode = 8'hAA;
        step;
        check("fb_sub_cin", 64'(p_o[0]), 64'(ONES));
        check("fb_sub_cin_co", 64'(co_o[0]), 64'd1);

        // carry register hold with CECY=0
        CECY = 1'b0; opmode = 8'h0D; C = 48'd3; M = 36'd4;
        step;
        check("cecy_hold", 64'(co_o[0]), 64'd1);
        check("cecy_p_loads", 64'(p_o[0]), 64'd7);
        CECY = 1'b1;

        // PCIN + M
        opmode = 8'h05; PCIN = 48'd1000; M = 36'd24;
        step;
        check("pcin_add", 64'(p_o[0]), 64'd1024);

        // random traffic checked by the model
        for (int n = 0; n < 60; n++) begin
            opmode  = 8'($urandom);
            M       = {4'($urandom), 32'($urandom)};
            DAB     = {16'($urandom), 32'($urandom)};
            C       = {16'($urandom), 32'($urandom)};
            PCIN    = {16'($urandom), 32'($urandom)};
            CARRYIN = 1'($urandom);
            CEP     = ($urandom_range(0, 3) != 0);
            CECY    = ($urandom_range(0, 3) != 0);
            step;
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
